// File: rtl/sync_fifo_w4.sv
// Single-clock FIFO, DEPTH x DATA_WIDTH, registered read data.
// Status flags come from a registered occupancy count, so they never glitch.
module sync_fifo_w4 #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_a,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  wr_acc;
    logic                  rd_acc;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst_a && wr_acc)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_w4.sv
// Directed bench for sync_fifo_w4: reset, fill/drain, wrap, simultaneous access,
// and reset in the middle of traffic.
module tb_sync_fifo_w4;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] data_in = '0;
    logic [3:0] data_out;
    logic       full;
    logic       empty;

    int errors = 0;
    int checks = 0;

    sync_fifo_w4 #(.DATA_WIDTH(4), .DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk      (clk),
        .rst_a    (rst_a),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs sampled at the same point.
    task automatic step(input logic r, input logic w, input logic rd, input logic [3:0] d);
        rst_a   = r;
        wr_en   = w;
        rd_en   = rd;
        data_in = d;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with a write pending: nothing must be stored
        step(1, 1, 0, 4'h0);
        chk("rst_empty", 8'(empty), 8'h1);
        chk("rst_full", 8'(full), 8'h0);
        chk("rst_dout", 8'(data_out), 8'h0);

        // Fill 0..F
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 0, 4'(i));
            chk("fill_empty", 8'(empty), 8'h0);
            chk("fill_full", 8'(full), (i == 15) ? 8'h1 : 8'h0);
        end
        step(0, 1, 0, 4'h5);
        chk("ovf_full", 8'(full), 8'h1);
        chk("ovf_dout", 8'(data_out), 8'h0);

        // Drain
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 4'h0);
            chk("drain_dout", 8'(data_out), 8'(i));
            chk("drain_full", 8'(full), 8'h0);
            chk("drain_empty", 8'(empty), (i == 15) ? 8'h1 : 8'h0);
        end
        step(0, 0, 1, 4'h0);
        chk("udf_dout", 8'(data_out), 8'hF);
        chk("udf_empty", 8'(empty), 8'h1);

        // Wrap-around: two batches of 10 push pointers past DEPTH-1
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 10; i++) begin
                step(0, 1, 0, (b == 0) ? 4'((i + 3) & 15) : 4'(15 - i));
                chk("wrap_wr_empty", 8'(empty), 8'h0);
                chk("wrap_wr_full", 8'(full), 8'h0);
            end
            for (int i = 0; i < 10; i++) begin
                step(0, 0, 1, 4'h0);
                chk("wrap_dout", 8'(data_out), (b == 0) ? 8'((i + 3) & 15) : 8'(15 - i));
                chk("wrap_rd_empty", 8'(empty), (i == 9) ? 8'h1 : 8'h0);
            end
        end

        // Both enables at empty: write only, no read-through
        step(0, 1, 1, 4'h9);
        chk("sim_e_empty", 8'(empty), 8'h0);
        chk("sim_e_dout", 8'(data_out), 8'h6);
        step(0, 0, 1, 4'h0);
        chk("sim_e_rd", 8'(data_out), 8'h9);
        chk("sim_e_empty2", 8'(empty), 8'h1);

        // Both enables at full: read only, incoming word dropped
        for (int i = 0; i < 16; i++)
            step(0, 1, 0, 4'((i * 3) & 15));
        chk("sim_f_full0", 8'(full), 8'h1);
        step(0, 1, 1, 4'hE);
        chk("sim_f_full", 8'(full), 8'h0);
        chk("sim_f_dout", 8'(data_out), 8'h0);
        for (int i = 1; i < 16; i++) begin
            step(0, 0, 1, 4'h0);
            chk("sim_f_drain", 8'(data_out), 8'((i * 3) & 15));
            chk("sim_f_empty", 8'(empty), (i == 15) ? 8'h1 : 8'h0);
        end

        // Both enables at count=5: occupancy stays 5, order kept
        for (int i = 1; i <= 5; i++)
            step(0, 1, 0, 4'(i));
        step(0, 1, 1, 4'h6);
        chk("sim_5_dout", 8'(data_out), 8'h1);
        chk("sim_5_empty", 8'(empty), 8'h0);
        for (int i = 2; i <= 6; i++) begin
            step(0, 0, 1, 4'h0);
            chk("sim_5_drain", 8'(data_out), 8'(i));
            chk("sim_5_empty2", 8'(empty), (i == 6) ? 8'h1 : 8'h0);
        end

        // Reset with 8 words stored
        for (int i = 0; i < 8; i++)
            step(0, 1, 0, 4'(8 + i));
        chk("mid_pre_empty", 8'(empty), 8'h0);
        step(1, 1, 0, 4'h5);
        chk("mid_rst_empty", 8'(empty), 8'h1);
        chk("mid_rst_full", 8'(full), 8'h0);
        chk("mid_rst_dout", 8'(data_out), 8'h0);
        step(0, 1, 0, 4'h5);
        chk("mid_wr_empty", 8'(empty), 8'h0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 4'h0);
            chk("mid_rd_dout", 8'(data_out), 8'h5);
            chk("mid_rd_empty", 8'(empty), 8'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
